// File: rtl/cv32e40p_pkg.sv
// Shared types and sizing for the APU write-back buffer.
package cv32e40p_pkg;

  localparam int unsigned APU_WB_DEPTH = 2;

  typedef struct packed {
    logic [5:0]  waddr;
    logic [31:0] data;
    logic [4:0]  flags;
  } apu_wb_entry_t;

endpackage

// File: rtl/cv32e40p_apu_wb_buf.sv
// In-order buffer for APU results competing with the core pipeline for the
// regfile write port; bypasses when empty, drains whenever the port is free.
module cv32e40p_apu_wb_buf
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH        = APU_WB_DEPTH,
  parameter int unsigned STALL_THRESH = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            apu_rvalid_i,
  input  logic [31:0]     apu_result_i,
  input  logic [4:0]      apu_flags_i,
  input  logic [5:0]      apu_waddr_i,
  input  logic            wb_port_busy_i,
  output logic            wb_we_o,
  output logic [5:0]      wb_waddr_o,
  output logic [31:0]     wb_wdata_o,
  output logic            fflags_we_o,
  output logic [4:0]      fflags_o,
  input  logic [2:0][5:0] read_regs_i,
  input  logic [2:0]      read_regs_valid_i,
  output logic            read_dep_o,
  input  logic [1:0][5:0] write_regs_i,
  input  logic [1:0]      write_regs_valid_i,
  output logic            write_dep_o,
  output logic            stall_o,
  output logic            empty_o,
  output logic            overflow_o,
  output logic            perf_wb_stall_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  apu_wb_entry_t              entry_q [DEPTH];
  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [PTR_W-1:0]           rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       overflow_q, overflow_d;

  logic empty, full, bypass, drain, push;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign bypass = empty & apu_rvalid_i & ~wb_port_busy_i;
  assign drain  = ~empty & ~wb_port_busy_i;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push   = apu_rvalid_i & ~bypass & (~full | drain);

  always_comb begin
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    if (drain) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wptr_q] = 1'b1;
      wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (push && !drain) count_d = count_q + 1'b1;
    else if (drain && !push) count_d = count_q - 1'b1;
    if (apu_rvalid_i && !bypass && !push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload needs no reset: an entry is only visible through valid_q/count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      entry_q[wptr_q] <= '{waddr: apu_waddr_i, data: apu_result_i, flags: apu_flags_i};
    end
  end

  always_comb begin
    wb_we_o    = 1'b0;
    wb_waddr_o = '0;
    wb_wdata_o = '0;
    fflags_o   = '0;
    if (bypass) begin
      wb_we_o    = 1'b1;
      wb_waddr_o = apu_waddr_i;
      wb_wdata_o = apu_result_i;
      fflags_o   = apu_flags_i;
    end else if (drain) begin
      wb_we_o    = 1'b1;
      wb_waddr_o = entry_q[rptr_q].waddr;
      wb_wdata_o = entry_q[rptr_q].data;
      fflags_o   = entry_q[rptr_q].flags;
    end
  end

  // The draining head is written this cycle, so it no longer creates a hazard.
  always_comb begin
    read_dep_o  = 1'b0;
    write_dep_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && !(drain && (rptr_q == PTR_W'(i)))) begin
        for (int r = 0; r < 3; r++) begin
          if (read_regs_valid_i[r] && (read_regs_i[r] == entry_q[i].waddr)) read_dep_o = 1'b1;
        end
        for (int w = 0; w < 2; w++) begin
          if (write_regs_valid_i[w] && (write_regs_i[w] == entry_q[i].waddr)) write_dep_o = 1'b1;
        end
      end
    end
  end

  assign fflags_we_o     = wb_we_o;
  assign stall_o         = (count_q >= CNT_W'(STALL_THRESH)) | (apu_rvalid_i & wb_port_busy_i);
  assign empty_o         = empty;
  assign overflow_o      = overflow_q;
  assign perf_wb_stall_o = ~empty & wb_port_busy_i;

endmodule

// File: tb/tb_cv32e40p_apu_wb_buf.sv
// Directed self-checking bench for the APU write-back buffer (DEPTH=2).
module tb_cv32e40p_apu_wb_buf;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            apu_rvalid_i;
  logic [31:0]     apu_result_i;
  logic [4:0]      apu_flags_i;
  logic [5:0]      apu_waddr_i;
  logic            wb_port_busy_i;
  logic            wb_we_o;
  logic [5:0]      wb_waddr_o;
  logic [31:0]     wb_wdata_o;
  logic            fflags_we_o;
  logic [4:0]      fflags_o;
  logic [2:0][5:0] read_regs_i;
  logic [2:0]      read_regs_valid_i;
  logic            read_dep_o;
  logic [1:0][5:0] write_regs_i;
  logic [1:0]      write_regs_valid_i;
  logic            write_dep_o;
  logic            stall_o;
  logic            empty_o;
  logic            overflow_o;
  logic            perf_wb_stall_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  cv32e40p_apu_wb_buf dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .apu_rvalid_i       (apu_rvalid_i),
    .apu_result_i       (apu_result_i),
    .apu_flags_i        (apu_flags_i),
    .apu_waddr_i        (apu_waddr_i),
    .wb_port_busy_i     (wb_port_busy_i),
    .wb_we_o            (wb_we_o),
    .wb_waddr_o         (wb_waddr_o),
    .wb_wdata_o         (wb_wdata_o),
    .fflags_we_o        (fflags_we_o),
    .fflags_o           (fflags_o),
    .read_regs_i        (read_regs_i),
    .read_regs_valid_i  (read_regs_valid_i),
    .read_dep_o         (read_dep_o),
    .write_regs_i       (write_regs_i),
    .write_regs_valid_i (write_regs_valid_i),
    .write_dep_o        (write_dep_o),
    .stall_o            (stall_o),
    .empty_o            (empty_o),
    .overflow_o         (overflow_o),
    .perf_wb_stall_o    (perf_wb_stall_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge; outputs are combinational and settle by #1.
  task automatic drive(input logic rv, input logic [5:0] wa, input logic [31:0] d,
                       input logic [4:0] fl, input logic busy);
    @(negedge clk_i);
    apu_rvalid_i   = rv;
    apu_waddr_i    = wa;
    apu_result_i   = d;
    apu_flags_i    = fl;
    wb_port_busy_i = busy;
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [5:0] wa,
                        input logic [31:0] d, input logic [4:0] fl);
    chk({tag, "_we"}, 32'(wb_we_o), 32'(we));
    chk({tag, "_fwe"}, 32'(fflags_we_o), 32'(we));
    chk({tag, "_waddr"}, 32'(wb_waddr_o), 32'(wa));
    chk({tag, "_wdata"}, wb_wdata_o, d);
    chk({tag, "_flags"}, 32'(fflags_o), 32'(fl));
    $display("txn %s: we=%0d waddr=%0d wdata=%08h flags=%02h", tag, wb_we_o, wb_waddr_o, wb_wdata_o, fflags_o);
  endtask

  initial begin
    rst_ni             = 1'b0;
    apu_rvalid_i       = 1'b0;
    apu_result_i       = '0;
    apu_flags_i        = '0;
    apu_waddr_i        = '0;
    wb_port_busy_i     = 1'b0;
    read_regs_i        = '0;
    read_regs_valid_i  = '0;
    write_regs_i       = '0;
    write_regs_valid_i = '0;

    // Reset state
    #12;
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_fwe", 32'(fflags_we_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_rdep", 32'(read_dep_o), 32'd0);
    chk("rst_wdep", 32'(write_dep_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Bypass
    drive(1'b1, 6'd5, 32'h1234_5678, 5'h03, 1'b0);
    chk_wb("bypass", 1'b1, 6'd5, 32'h1234_5678, 5'h03);
    chk("bypass_empty", 32'(empty_o), 32'd1);
    chk("bypass_stall", 32'(stall_o), 32'd0);
    drive(1'b0, 6'd9, 32'hFFFF_FFFF, 5'h1F, 1'b0);
    chk_wb("idle", 1'b0, 6'd0, 32'd0, 5'd0);
    chk("idle_empty", 32'(empty_o), 32'd1);

    // Buffering r3 then r4 while the port is busy
    drive(1'b1, 6'd3, 32'hA3A3_0003, 5'h01, 1'b1);
    chk_wb("buf_r3", 1'b0, 6'd0, 32'd0, 5'd0);
    chk("buf_r3_stall", 32'(stall_o), 32'd1);
    drive(1'b1, 6'd4, 32'hA4A4_0004, 5'h02, 1'b1);
    chk("buf_r4_empty", 32'(empty_o), 32'd0);
    chk("buf_r4_perf", 32'(perf_wb_stall_o), 32'd1);
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
    chk("buf_cnt2_stall", 32'(stall_o), 32'd1);
    read_regs_i[1] = 6'd4; read_regs_valid_i = 3'b010; #1;
    chk("rdep_r4", 32'(read_dep_o), 32'd1);
    read_regs_i[1] = 6'd9; #1;
    chk("rdep_r9", 32'(read_dep_o), 32'd0);
    write_regs_i[0] = 6'd3; write_regs_valid_i = 2'b01; #1;
    chk("wdep_r3", 32'(write_dep_o), 32'd1);
    write_regs_valid_i = 2'b00; #1;
    chk("wdep_nov", 32'(write_dep_o), 32'd0);
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
    read_regs_i[1] = 6'd3; #1;
    chk("rdep_head_drain", 32'(read_dep_o), 32'd0);
    chk_wb("drain_r3", 1'b1, 6'd3, 32'hA3A3_0003, 5'h01);
    read_regs_valid_i = 3'b000;
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
    chk_wb("drain_r4", 1'b1, 6'd4, 32'hA4A4_0004, 5'h02);
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
    chk("drained_empty", 32'(empty_o), 32'd1);
    chk("drained_stall", 32'(stall_o), 32'd0);

    // Full plus drain
    drive(1'b1, 6'd1, 32'h0000_0011, 5'h04, 1'b1);
    drive(1'b1, 6'd2, 32'h0000_0022, 5'h08, 1'b1);
    drive(1'b1, 6'd7, 32'h0000_0077, 5'h10, 1'b0);
    chk_wb("full_drain_r1", 1'b1, 6'd1, 32'h0000_0011, 5'h04);
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
    chk("full_drain_ovf", 32'(overflow_o), 32'd0);
    chk("full_drain_empty", 32'(empty_o), 32'd0);

    // Overflow while full and busy
    drive(1'b1, 6'd8, 32'h0000_0088, 5'h1F, 1'b1);
    chk("ovf_pre", 32'(overflow_o), 32'd0);
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("ovf_stall", 32'(stall_o), 32'd1);
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
    chk_wb("ovf_drain_r2", 1'b1, 6'd2, 32'h0000_0022, 5'h08);
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
    chk_wb("ovf_drain_r7", 1'b1, 6'd7, 32'h0000_0077, 5'h10);
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
    chk_wb("ovf_after", 1'b0, 6'd0, 32'd0, 5'd0);
    chk("ovf_sticky", 32'(overflow_o), 32'd1);
    chk("ovf_empty", 32'(empty_o), 32'd1);

    // Wrap: five enqueue/drain pairs
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 6'(k), 32'hC0DE_0000 + 32'(k), 5'(k), 1'b1);
      chk($sformatf("wrap_q%0d_we", k), 32'(wb_we_o), 32'd0);
      drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
      chk_wb($sformatf("wrap_d%0d", k), 1'b1, 6'(k), 32'hC0DE_0000 + 32'(k), 5'(k));
    end
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
    chk("wrap_empty", 32'(empty_o), 32'd1);

    // Reset mid-operation
    drive(1'b1, 6'd10, 32'h0000_0100, 5'h01, 1'b1);
    drive(1'b1, 6'd11, 32'h0000_0110, 5'h02, 1'b1);
    drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
    chk("mid_empty_pre", 32'(empty_o), 32'd0);
    wb_port_busy_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(empty_o), 32'd1);
    chk("mid_rst_we", 32'(wb_we_o), 32'd0);
    chk("mid_rst_ovf", 32'(overflow_o), 32'd0);
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
      chk_wb($sformatf("post_rst%0d", c), 1'b0, 6'd0, 32'd0, 5'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_apu_wb_buf.md
CV32E40P_APU_WB_BUF -- requirements
Module: cv32e40p_apu_wb_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered APU results (legal 2..8).
REQ-002 SHALL have parameter STALL_THRESH, default 1, occupancy at or above which stall_o asserts (legal 1..DEPTH).
REQ-003 SHALL have port clk_i  input  1  clock; reset rst_ni, asynchronous, active-low.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port apu_rvalid_i  input  1  APU result valid this cycle.
REQ-006 SHALL have port apu_result_i  input  32  APU result data.
REQ-007 SHALL have port apu_flags_i  input  5  APU FP exception flags.
REQ-008 SHALL have port apu_waddr_i  input  6  destination register from dispatcher, valid with apu_rvalid_i.
REQ-009 SHALL have port wb_port_busy_i  input  1  regfile write port claimed by the core pipeline this cycle.
REQ-010 SHALL have port wb_we_o  output  1  regfile write enable.
REQ-011 SHALL have port wb_waddr_o  output  6  regfile write address.
REQ-012 SHALL have port wb_wdata_o  output  32  regfile write data.
REQ-013 SHALL have port fflags_we_o  output  1  fflags update strobe, equal to wb_we_o.
REQ-014 SHALL have port fflags_o  output  5  flags accompanying wb_wdata_o.
REQ-015 SHALL have port read_regs_i  input  3x6  decode-stage source registers.
REQ-016 SHALL have port read_regs_valid_i  input  3  source register valids.
REQ-017 SHALL have port read_dep_o  output  1  a source matches a buffered, unwritten destination.
REQ-018 SHALL have port write_regs_i  input  2x6  decode-stage destination registers.
REQ-019 SHALL have port write_regs_valid_i  input  2  destination valids.
REQ-020 SHALL have port write_dep_o  output  1  a destination matches a buffered entry (WAW).
REQ-021 SHALL have port stall_o  output  1  backpressure to dispatcher/issue.
REQ-022 SHALL have port empty_o  output  1  no buffered entries.
REQ-023 SHALL have port overflow_o  output  1  sticky error, result lost.
REQ-024 SHALL have port perf_wb_stall_o  output  1  entries waiting while port busy.

Function
REQ-025 SHALL write results in arrival order; no reordering.
REQ-026 SHALL bypass: empty, apu_rvalid_i=1, wb_port_busy_i=0 -> same-cycle write of input data/addr/flags, nothing stored.
REQ-027 SHALL drain: not empty, wb_port_busy_i=0 -> write head entry combinationally, pop at clock edge.
REQ-028 SHALL enqueue apu_rvalid_i when not bypassed, including same cycle as a drain (count unchanged).
REQ-029 SHALL assert wb_we_o only when wb_port_busy_i=0; wb_waddr_o/wb_wdata_o/fflags_o SHALL be 0 when wb_we_o=0.
REQ-030 SHALL keep read/write pointers of width clog2(DEPTH), wrapping DEPTH-1 -> 0; count 0..DEPTH.
REQ-031 SHALL, on apu_rvalid_i with count=DEPTH and no drain, drop the result and set overflow_o until reset.
REQ-032 SHALL allow enqueue when full if a drain occurs the same cycle.
REQ-033 SHALL assert stall_o = (count >= STALL_THRESH) | (apu_rvalid_i & wb_port_busy_i).
REQ-034 SHALL compute read_dep_o/write_dep_o over stored valid entries only, excluding the head when it drains this cycle.
REQ-035 SHALL assert perf_wb_stall_o = !empty & wb_port_busy_i.
REQ-036 SHALL ignore apu_waddr_i/data when apu_rvalid_i=0.

Reset
REQ-037 SHALL, on rst_ni low, clear pointers, count, entry valids, and overflow_o immediately.
REQ-038 SHALL drive reset outputs: wb_we_o=0, fflags_we_o=0, stall_o=0 (given apu_rvalid_i=0), empty_o=1, read_dep_o=0, write_dep_o=0.
REQ-039 SHALL discard buffered entries on reset mid-operation; no write after release until new apu_rvalid_i.

Structure
REQ-040 SHALL place APU_WB_DEPTH and an apu_wb_entry_t struct (waddr, data, flags) in cv32e40p_pkg.
REQ-041 SHALL implement storage inline; no sub-module.

Verification
REQ-042 SHALL test bypass: empty, rvalid, waddr=5, data=0x12345678, busy=0 -> same cycle wb_we_o=1, wb_waddr_o=5, empty_o stays 1.
REQ-043 SHALL test buffering: busy=1, results to r3 then r4 -> count 2, stall_o=1, read_dep_o=1 for r4; busy=0 -> r3 then r4 on consecutive cycles.
REQ-044 SHALL test full plus drain: DEPTH=2 full, busy=0, rvalid to r7 -> head written, r7 stored, count 2, overflow_o=0.
REQ-045 SHALL test overflow: full, busy=1, rvalid -> overflow_o=1 sticky, count 2, stored data unchanged.
REQ-046 SHALL test wrap: DEPTH=2, 5 enqueue/drain pairs with busy toggling -> writes in order r1..r5, pointers wrap, no loss.
REQ-047 SHALL test reset mid-operation: count 2, rst_ni low -> empty_o=1, wb_we_o=0, no further writes after release.
